// File: rtl/logic_sweep_pkg.sv
// Shared types and sizes for the logic sweep controller.
package logic_sweep_pkg;

  localparam int VEC_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int ERR_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/logic_sweep_sync.sv
// Two-flop synchronizer for the observed logic-block output.
module logic_sweep_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive 4-input truth-table sweep controller.
// Drives all 16 input vectors onto a logic block, waits SETTLE_CYCLES per
// vector, samples the block output and compares it against TT_EXPECT.
// Optional macro LOGIC_SWEEP_SYNC_EN inserts a 2-flop synchronizer on
// dut_out and lengthens each settle dwell by 2 cycles to cover its latency.
//
// Control semantics: start is a single-cycle request, accepted only in IDLE
// (ignored while busy and in FINISH). abort is level-sampled and, in SETTLE
// or SAMPLE, wins over both start and the sample in that cycle; abort in
// IDLE or FINISH does nothing.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] TT_EXPECT     = 16'h3B68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_mask,
  output logic [4:0]  err_count
);

`ifdef LOGIC_SWEEP_SYNC_EN
  localparam int unsigned SYNC_EXTRA = 2;
`else
  localparam int unsigned SYNC_EXTRA = 0;
`endif

  // Settle counter is 9 bits so 255 + 2 extra cycles still fits.
  localparam logic [8:0]       SETTLE_LAST = 9'(SETTLE_CYCLES + SYNC_EXTRA - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(VEC_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(VEC_COUNT);

  sweep_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [8:0]       settle_cnt;
  logic             sample_bit;
  logic             mismatch_now;

`ifdef LOGIC_SWEEP_SYNC_EN
  logic_sweep_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (sample_bit)
  );
`else
  assign sample_bit = dut_out;
`endif

  // The applied vector is always the current index; it returns to 0 on
  // reset, abort and after the last vector.
  assign dut_in = idx;

  // Compare the observed bit against the expected table entry for this vector.
  assign mismatch_now = (sample_bit != TT_EXPECT[idx]);

  // Sweep FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      settle_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      err_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_SETTLE;
            idx           <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b1;
            pass          <= 1'b0;
            mismatch_mask <= '0;
            err_count     <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 9'd1;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            if (mismatch_now) begin
              mismatch_mask[idx] <= 1'b1;
              if (err_count != ERR_MAX) err_count <= err_count + 5'd1;
            end
            idx <= idx + 4'd1;
            if (idx == IDX_LAST) begin
              // Last vector: final error total includes this sample.
              state <= ST_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch_now;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
